ucr_step_arbiter: RTL and testbench

UCR_STEP_ARBITER -- requirements
Module: ucr_step_arbiter

---
 rtl/ucr_step_arbiter.sv | 150 +++++++++++++++
 tb/tb_ucr_step_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucr_step_arbiter.sv
// Round-robin arbiter sharing one cascaded LOAD/DEC/INC/HOLD step counter between two requesters.
// Grant one cycle after an IDLE request, CNT = D one cycle later; STALL holds the count, the loser waits in IDLE.
module ucr_step_arbiter #(
  parameter int NSLICE = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_A,
  input  logic                REQ_B,
  input  logic [0:4*NSLICE-1] D_A,
  input  logic [0:4*NSLICE-1] D_B,
  input  logic                UP_A,
  input  logic                UP_B,
  input  logic                STALL,
  output logic                GNT_A,
  output logic                GNT_B,
  output logic [0:4*NSLICE-1] CNT,
  output logic                BUSY,
  output logic                DONE
);
  localparam int W = 4 * NSLICE;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COUNT, ST_DONE} state_t;
  typedef enum logic [1:0] {SEL_HOLD, SEL_LOAD, SEL_DEC, SEL_INC} sel_t;

  state_t         state;
  sel_t           sel;
  logic           up_dir;
  logic           last_b;
  logic           own_req;
  logic           own_up;
  logic           cnt_zero;
  logic           carry_msb;
  logic           c;
  logic [3:0]     q;
  logic [3:0]     nq;
  logic [0:W-1]   own_d;
  logic [0:W-1]   cnt_next;

  assign own_req  = GNT_B ? REQ_B : REQ_A;
  assign own_d    = GNT_B ? D_B   : D_A;
  assign own_up   = GNT_B ? UP_B  : UP_A;
  assign cnt_zero = (CNT == '0);

  // A down count parked at zero holds rather than wrapping; withdrawal also holds.
  always_comb begin
    sel = SEL_HOLD;
    if (state == ST_LOAD && own_req) begin
      sel = SEL_LOAD;
    end else if (state == ST_COUNT && own_req && !STALL) begin
      if (up_dir) begin
        sel = SEL_INC;
      end else if (!cnt_zero) begin
        sel = SEL_DEC;
      end
    end
  end

  // Slice 0 is the least significant nibble; each slice's carry/borrow feeds the next.
  always_comb begin
    c        = 1'b1;
    cnt_next = CNT;
    q        = '0;
    nq       = '0;
    for (int k = 0; k < NSLICE; k++) begin
      q = CNT[W-4*k-4 +: 4];
      case (sel)
        SEL_LOAD: begin
          nq = own_d[W-4*k-4 +: 4];
          c  = 1'b0;
        end
        SEL_INC: begin
          nq = q + {3'b000, c};
          c  = c & (q == 4'hF);
        end
        SEL_DEC: begin
          nq = q - {3'b000, c};
          c  = c & (q == 4'h0);
        end
        default: begin
          nq = q;
          c  = 1'b0;
        end
      endcase
      cnt_next[W-4*k-4 +: 4] = nq;
    end
    carry_msb = c;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      CNT    <= '0;
      GNT_A  <= 1'b0;
      GNT_B  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      up_dir <= 1'b0;
      last_b <= 1'b1;
    end else begin
      CNT  <= cnt_next;
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ_A && (!REQ_B || last_b)) begin
            GNT_A <= 1'b1;
            BUSY  <= 1'b1;
            state <= ST_LOAD;
          end else if (REQ_B) begin
            GNT_B <= 1'b1;
            BUSY  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!own_req) begin
            state  <= ST_IDLE;
            GNT_A  <= 1'b0;
            GNT_B  <= 1'b0;
            BUSY   <= 1'b0;
            last_b <= GNT_B;
          end else begin
            up_dir <= own_up;
            state  <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!own_req) begin
            state  <= ST_IDLE;
            GNT_A  <= 1'b0;
            GNT_B  <= 1'b0;
            BUSY   <= 1'b0;
            last_b <= GNT_B;
          end else if (!STALL && (up_dir ? carry_msb : cnt_zero)) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          GNT_A  <= 1'b0;
          GNT_B  <= 1'b0;
          last_b <= GNT_B;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ucr_step_arbiter.sv
// Scoreboard bench for ucr_step_arbiter (NSLICE = 3, W = 12): per-cycle expected observations queued with the stimulus.
module tb_ucr_step_arbiter;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_A = 1'b0;
  logic        REQ_B = 1'b0;
  logic [0:11] D_A = '0;
  logic [0:11] D_B = '0;
  logic        UP_A = 1'b0;
  logic        UP_B = 1'b0;
  logic        STALL = 1'b0;
  logic        GNT_A;
  logic        GNT_B;
  logic [0:11] CNT;
  logic        BUSY;
  logic        DONE;

  typedef struct packed {
    logic        ga;
    logic        gb;
    logic        busy;
    logic        dn;
    logic [11:0] cnt;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic stall;
    logic ra;
    logic rb;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ucr_step_arbiter #(.NSLICE(3)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .D_A(D_A), .D_B(D_B), .UP_A(UP_A), .UP_B(UP_B), .STALL(STALL),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .CNT(CNT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic obs_t got();
    obs_t o;
    o.ga   = GNT_A;
    o.gb   = GNT_B;
    o.busy = BUSY;
    o.dn   = DONE;
    o.cnt  = CNT;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("gnt_a=%b gnt_b=%b busy=%b done=%b cnt=%h", o.ga, o.gb, o.busy, o.dn, o.cnt);
  endfunction

  task automatic push(input bit ga, input bit gb, input bit busy, input bit dn,
                      input logic [11:0] cnt, input bit st, input bit ra, input bit rb);
    exp_t e;
    e.o.ga = ga; e.o.gb = gb; e.o.busy = busy; e.o.dn = dn; e.o.cnt = cnt;
    e.stall = st; e.ra = ra; e.rb = rb;
    sb.push_back(e);
  endtask

  // Expected trace of one complete operation: grant, COUNT values (stalls repeat a value), DONE, IDLE.
  task automatic push_op(input bit is_b, input logic [11:0] prev, input logic [11:0] d, input bit up,
                         input int s_idx, input int s_len,
                         input bit ra_run, input bit rb_run, input bit ra_end, input bit rb_end);
    logic [11:0] v;
    int          n;
    bit          fin;
    v   = d;
    n   = 0;
    fin = 1'b0;
    push(!is_b, is_b, 1, 0, prev, 0, ra_run, rb_run);
    while (!fin) begin
      push(!is_b, is_b, 1, 0, v, (n == s_idx) && (s_len > 0), ra_run, rb_run);
      if (n == s_idx)
        for (int j = 1; j <= s_len; j++) push(!is_b, is_b, 1, 0, v, j < s_len, ra_run, rb_run);
      if ((!up && v == 12'h000) || (up && v == 12'hFFF)) fin = 1'b1;
      v = up ? v + 12'd1 : v - 12'd1;
      n++;
    end
    push(!is_b, is_b, 0, 1, 12'h000, 0, ra_end, rb_end);
    push(0, 0, 0, 0, 12'h000, 0, ra_end, rb_end);
  endtask

  task automatic test_reset();
    obs_t z;
    z = '0;
    RESET = 1'b1;
    REQ_A = 1'b1;
    tick(); tick();
    checks++;
    if (got() !== z) begin errors++; $display("FAIL reset_with_req: got %s want %s", fmt(got()), fmt(z)); end
    REQ_A = 1'b0;
    tick();
    checks++;
    if (got() !== z) begin errors++; $display("FAIL reset_hold: got %s want %s", fmt(got()), fmt(z)); end
    RESET = 1'b0;
    tick();
    checks++;
    if (got() !== z) begin errors++; $display("FAIL idle_no_req: got %s want %s", fmt(got()), fmt(z)); end
  endtask

  task automatic test_down5();
    int   n = 0;
    exp_t e;
    D_A = 12'd5; UP_A = 1'b0; REQ_A = 1'b1;
    push_op(0, 12'h000, 12'd5, 0, -1, 0, 1, 0, 0, 0);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (got() !== e.o) begin errors++; $display("FAIL down5 step%0d: got %s want %s", n, fmt(got()), fmt(e.o)); end
      STALL = e.stall; REQ_A = e.ra; REQ_B = e.rb;
      if (n == 2) begin D_A = 12'h0AA; UP_A = 1'b1; end
      n++;
    end
  endtask

  task automatic test_up_wrap();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      int n = 0;
      if (pass == 0) begin
        D_A = 12'hFFE; UP_A = 1'b1;
        push_op(0, 12'h000, 12'hFFE, 1, -1, 0, 1, 0, 0, 0);
      end else begin
        D_A = 12'h000; UP_A = 1'b0;
        push_op(0, 12'h000, 12'h000, 0, -1, 0, 1, 0, 0, 0);
      end
      REQ_A = 1'b1;
      while (sb.size() > 0) begin
        tick();
        e = sb.pop_front();
        checks++;
        if (got() !== e.o) begin errors++; $display("FAIL up_wrap pass%0d step%0d: got %s want %s", pass, n, fmt(got()), fmt(e.o)); end
        STALL = e.stall; REQ_A = e.ra; REQ_B = e.rb;
        n++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int   n = 0;
    exp_t e;
    obs_t z;
    obs_t g;
    z = '0;
    g = '0; g.ga = 1'b1; g.busy = 1'b1;
    D_A = 12'd12; UP_A = 1'b0; REQ_A = 1'b1;
    push(1, 0, 1, 0, 12'h000, 0, 1, 0);
    push(1, 0, 1, 0, 12'd12,  0, 1, 0);
    push(1, 0, 1, 0, 12'd11,  0, 1, 0);
    push(1, 0, 1, 0, 12'd10,  0, 1, 0);
    push(1, 0, 1, 0, 12'd9,   0, 1, 1);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (got() !== e.o) begin errors++; $display("FAIL reset_mid step%0d: got %s want %s", n, fmt(got()), fmt(e.o)); end
      STALL = e.stall; REQ_A = e.ra; REQ_B = e.rb;
      n++;
    end
    RESET = 1'b1;
    tick();
    checks++;
    if (got() !== z) begin errors++; $display("FAIL reset_mid_clear: got %s want %s", fmt(got()), fmt(z)); end
    RESET = 1'b0;
    tick();
    checks++;
    if (got() !== g) begin errors++; $display("FAIL reset_mid_tie_a: got %s want %s", fmt(got()), fmt(g)); end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    checks++;
    if (got() !== z) begin errors++; $display("FAIL withdraw_in_load: got %s want %s", fmt(got()), fmt(z)); end
  endtask

  task automatic test_stall();
    int   n = 0;
    exp_t e;
    D_B = 12'd3; UP_B = 1'b0; REQ_B = 1'b1;
    push_op(1, 12'h000, 12'd3, 0, 1, 2, 0, 1, 0, 0);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (got() !== e.o) begin errors++; $display("FAIL stall step%0d: got %s want %s", n, fmt(got()), fmt(e.o)); end
      STALL = e.stall; REQ_A = e.ra; REQ_B = e.rb;
      n++;
    end
  endtask

  task automatic test_round_robin();
    int   n = 0;
    exp_t e;
    D_A = 12'd1; UP_A = 1'b0; D_B = 12'd2; UP_B = 1'b0;
    REQ_A = 1'b1; REQ_B = 1'b1;
    push_op(0, 12'h000, 12'd1, 0, -1, 0, 1, 1, 1, 1);
    push_op(1, 12'h000, 12'd2, 0, -1, 0, 1, 1, 1, 1);
    push_op(0, 12'h000, 12'd1, 0, -1, 0, 1, 1, 1, 1);
    push_op(1, 12'h000, 12'd2, 0, -1, 0, 1, 1, 0, 0);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (got() !== e.o) begin errors++; $display("FAIL round_robin step%0d: got %s want %s", n, fmt(got()), fmt(e.o)); end
      STALL = e.stall; REQ_A = e.ra; REQ_B = e.rb;
      n++;
    end
  endtask

  task automatic test_withdraw();
    int   n = 0;
    exp_t e;
    D_A = 12'd9; UP_A = 1'b0; D_B = 12'd0; UP_B = 1'b0;
    REQ_A = 1'b1; REQ_B = 1'b0;
    push(1, 0, 1, 0, 12'h000, 0, 1, 0);
    push(1, 0, 1, 0, 12'd9,   0, 1, 0);
    push(1, 0, 1, 0, 12'd8,   0, 1, 0);
    push(1, 0, 1, 0, 12'd7,   0, 0, 1);
    push(0, 0, 0, 0, 12'd7,   0, 0, 1);
    push(0, 1, 1, 0, 12'd7,   0, 0, 1);
    push(0, 1, 1, 0, 12'h000, 0, 0, 1);
    push(0, 1, 0, 1, 12'h000, 0, 0, 0);
    push(0, 0, 0, 0, 12'h000, 0, 0, 0);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (got() !== e.o) begin errors++; $display("FAIL withdraw step%0d: got %s want %s", n, fmt(got()), fmt(e.o)); end
      STALL = e.stall; REQ_A = e.ra; REQ_B = e.rb;
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_down5();
    test_up_wrap();
    test_reset_mid();
    test_stall();
    test_round_robin();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
